// File: rtl/lopd_norm_pipe.sv
// Two-stage leading/trailing-one detector with normaliser.
// Stage 1 registers the input word, its search direction and tag, along with
// the one-position and the zero flag. Stage 2 barrel-shifts the word so the
// detected one lands at the MSB (dir=0) or the LSB (dir=1), then registers
// every output. A valid/ready handshake on each side stalls the whole pipe
// without dropping or duplicating words.
module lopd_norm_pipe #(
    parameter int SIZE_DATA = 16,
    parameter int SIZE_POS  = $clog2(SIZE_DATA),
    parameter int SIZE_TAG  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                i_dir,
    input  logic [SIZE_TAG-1:0] i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_POS-1:0] o_pos_one,
    output logic                o_zero_flag,
    output logic [SIZE_DATA-1:0] o_norm_data,
    output logic [SIZE_TAG-1:0] o_tag
);

    // Counts leading zeros with a log-depth tree. Each level checks whether
    // the upper half of the remaining window is empty. If it is, the level
    // sets its bit of the count and drops that half. An all-zero word
    // returns SIZE_DATA-1, and the caller masks that case.
    function automatic logic [SIZE_POS-1:0] lead_zeros(input logic [SIZE_DATA-1:0] value);
        logic [SIZE_DATA-1:0] window;
        logic [SIZE_DATA-1:0] upper_mask;
        logic [SIZE_POS-1:0]  count;
        window = value;
        count  = '0;
        for (int lvl = SIZE_POS - 1; lvl >= 0; lvl--) begin
            upper_mask = ~({SIZE_DATA{1'b1}} >> (1 << lvl));
            if ((window & upper_mask) == '0) begin
                count[lvl] = 1'b1;
                window     = window << (1 << lvl);
            end
        end
        return count;
    endfunction

    // Reverses the bit order so the leading-zero tree can search from the LSB.
    function automatic logic [SIZE_DATA-1:0] bit_reverse(input logic [SIZE_DATA-1:0] value);
        logic [SIZE_DATA-1:0] rev;
        for (int b = 0; b < SIZE_DATA; b++) begin
            rev[b] = value[SIZE_DATA-1-b];
        end
        return rev;
    endfunction

    logic                 s1_valid;
    logic [SIZE_DATA-1:0] s1_data;
    logic                 s1_dir;
    logic [SIZE_TAG-1:0]  s1_tag;
    logic [SIZE_POS-1:0]  s1_pos;
    logic                 s1_zero;

    logic                 s2_valid;
    logic                 s1_adv;
    logic                 s2_adv;
    logic [SIZE_POS-1:0]  in_pos;
    logic                 in_zero;
    logic [SIZE_DATA-1:0] s1_norm;

    // Stall control: a stage moves when it is empty or its consumer moves.
    always_comb begin
        s2_adv  = !s2_valid || i_ready;
        s1_adv  = !s1_valid || s2_adv;
        o_ready = s1_adv;
    end

    // Stage 1 logic: find the position of the one and flag a zero word.
    always_comb begin
        // NOTE: every always_comb output gets a value first. No path can leave it unassigned, so no latch is inferred.
        in_pos  = '0;
        in_zero = (i_data == '0);
        if (!in_zero) begin
            in_pos = i_dir ? lead_zeros(bit_reverse(i_data)) : lead_zeros(i_data);
        end
    end

    // Stage 2 logic: shift the word by the registered position. Zeros fill the vacated bits.
    always_comb begin
        s1_norm = s1_dir ? (s1_data >> s1_pos) : (s1_data << s1_pos);
    end

    // Stage 1 register: load a new word whenever the stage can advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the datapath registers are reset as well as the valid flags, so every register leaves reset at zero.
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_dir   <= 1'b0;
            s1_tag   <= '0;
            s1_pos   <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, so stages do not race.
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_data <= i_data;
                s1_dir  <= i_dir;
                s1_tag  <= i_tag;
                s1_pos  <= in_pos;
                s1_zero <= in_zero;
            end
        end
    end

    // Stage 2 register: drive the outputs. They hold while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid    <= 1'b0;
            o_pos_one   <= '0;
            o_zero_flag <= 1'b0;
            o_norm_data <= '0;
            o_tag       <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_pos_one   <= s1_pos;
                o_zero_flag <= s1_zero;
                o_norm_data <= s1_norm;
                o_tag       <= s1_tag;
            end
        end
    end

    assign o_valid = s2_valid;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Directed testbench for lopd_norm_pipe: reset state, hand-computed vectors
// in both directions, an exhaustive 16-bit dir=0 sweep, backpressure,
// a random handshake stream scored against a reference model, reset with
// words in flight, and a 64-bit build.
module tb_lopd_norm_pipe;

    localparam int W = 16;
    localparam int P = 4;
    localparam int T = 4;

    typedef struct packed {
        logic         zero;
        logic [P-1:0] pos;
        logic [W-1:0] norm;
        logic [T-1:0] tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic         i_dir;
    logic [T-1:0] i_tag;
    logic         o_valid;
    logic         i_ready;
    logic [P-1:0] o_pos_one;
    logic         o_zero_flag;
    logic [W-1:0] o_norm_data;
    logic [T-1:0] o_tag;

    logic         w_valid;
    logic         w_o_ready;
    logic [63:0]  w_data;
    logic         w_dir;
    logic         w_o_valid;
    logic [5:0]   w_pos;
    logic         w_zero;
    logic [63:0]  w_norm;
    logic [3:0]   w_tag;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int sent     = 0;
    logic in_fire;
    logic out_fire;
    logic last_o_ready;
    logic ready_dropped;
    exp_t q[$];

    always #5 clk = ~clk;

    lopd_norm_pipe #(.SIZE_DATA(W), .SIZE_TAG(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_dir(i_dir), .i_tag(i_tag), .o_valid(o_valid),
        .i_ready(i_ready), .o_pos_one(o_pos_one), .o_zero_flag(o_zero_flag),
        .o_norm_data(o_norm_data), .o_tag(o_tag)
    );

    lopd_norm_pipe #(.SIZE_DATA(64), .SIZE_TAG(4)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid), .o_ready(w_o_ready),
        .i_data(w_data), .i_dir(w_dir), .i_tag(4'd0), .o_valid(w_o_valid),
        .i_ready(1'b1), .o_pos_one(w_pos), .o_zero_flag(w_zero),
        .o_norm_data(w_norm), .o_tag(w_tag)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a linear bit scan, independent of the tree in the RTL.
    function automatic exp_t model(input logic [W-1:0] d, input logic dir, input logic [T-1:0] tag);
        exp_t e;
        int   idx;
        idx    = 0;
        e.tag  = tag;
        e.zero = (d == '0);
        e.pos  = '0;
        e.norm = '0;
        if (d != '0) begin
            if (!dir) begin
                for (int b = 0; b < W; b++) if (d[b]) idx = b;
                e.pos  = P'(W - 1 - idx);
                e.norm = d << e.pos;
            end else begin
                for (int b = W - 1; b >= 0; b--) if (d[b]) idx = b;
                e.pos  = P'(idx);
                e.norm = d >> e.pos;
            end
        end
        return e;
    endfunction

    function automatic exp_t observed();
        return {o_zero_flag, o_pos_one, o_norm_data, o_tag};
    endfunction

    // One word through an idle pipe with i_ready=1; the expected values are given by hand.
    task automatic run_one(input string name, input logic [W-1:0] d, input logic dir,
                           input logic [T-1:0] tag, input exp_t exp);
        i_valid = 1'b1; i_data = d; i_dir = dir; i_tag = tag;
        tick();
        i_valid = 1'b0;
        check({name, "_lat1"}, 128'(o_valid), 128'(1'b0));
        tick();
        check({name, "_valid"}, 128'(o_valid), 128'(1'b1));
        check(name, 128'(observed()), 128'(exp));
    endtask

    // One clock of handshake traffic: score drained words, queue accepted ones, and check that outputs hold while stalled.
    task automatic cycle();
        exp_t snap;
        exp_t e;
        logic hold;
        #1;
        in_fire      = i_valid && o_ready;
        out_fire     = o_valid && i_ready;
        last_o_ready = o_ready;
        if (out_fire) begin
            if (q.size() == 0) begin
                check("sb_extra_word", 128'(1), 128'(0));
            end else begin
                e = q.pop_front();
                check("sb_word", 128'(observed()), 128'(e));
                n_out++;
            end
        end
        hold = o_valid && !i_ready;
        snap = observed();
        if (in_fire) q.push_back(model(i_data, i_dir, i_tag));
        tick();
        if (hold) begin
            check("hold_valid", 128'(o_valid), 128'(1'b1));
            check("hold_data", 128'(observed()), 128'(snap));
        end
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_dir = 1'b0; i_tag = '0; i_ready = 1'b1;
        w_valid = 1'b0; w_data = '0; w_dir = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_o_valid", 128'(o_valid), 128'(1'b0));
        check("rst_outputs", 128'(observed()), 128'(0));
        check("rst_o_ready", 128'(o_ready), 128'(1'b1));

        // Directed vectors, dir=0 (leading one from MSB)
        run_one("d0_0001", 16'h0001, 1'b0, 4'd1, {1'b0, 4'd15, 16'h8000, 4'd1});
        run_one("d0_8000", 16'h8000, 1'b0, 4'd2, {1'b0, 4'd0,  16'h8000, 4'd2});
        run_one("d0_00f0", 16'h00F0, 1'b0, 4'd3, {1'b0, 4'd8,  16'hF000, 4'd3});
        run_one("d0_1234", 16'h1234, 1'b0, 4'd4, {1'b0, 4'd3,  16'h91A0, 4'd4});
        run_one("d0_zero", 16'h0000, 1'b0, 4'd5, {1'b1, 4'd0,  16'h0000, 4'd5});
        // Directed vectors, dir=1 (trailing one from LSB)
        run_one("d1_zero", 16'h0000, 1'b1, 4'd6, {1'b1, 4'd0,  16'h0000, 4'd6});
        run_one("d1_8000", 16'h8000, 1'b1, 4'd7, {1'b0, 4'd15, 16'h0001, 4'd7});
        run_one("d1_0c00", 16'h0C00, 1'b1, 4'd8, {1'b0, 4'd10, 16'h0003, 4'd8});
        run_one("d1_0001", 16'h0001, 1'b1, 4'd9, {1'b0, 4'd0,  16'h0001, 4'd9});
        run_one("d1_1234", 16'h1234, 1'b1, 4'hA, {1'b0, 4'd2,  16'h048D, 4'hA});

        // Exhaustive dir=0 sweep at full throughput; word i-1 appears after word i is accepted.
        i_ready = 1'b1;
        for (int i = 0; i <= 65536; i++) begin
            if (i < 65536) begin
                i_valid = 1'b1; i_data = W'(i); i_dir = 1'b0; i_tag = T'(i);
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check("sweep", 128'({o_valid, observed()}),
                      128'({1'b1, model(W'(i - 1), 1'b0, T'(i - 1))}));
            end
        end
        tick();

        // Backpressure: tags 0..7 back to back, with i_ready held low for 5 cycles mid-stream.
        n_out = 0; sent = 0; ready_dropped = 1'b0; q.delete();
        for (int c = 0; c < 60 && (sent < 8 || q.size() > 0); c++) begin
            i_valid = (sent < 8);
            i_data  = W'(16'h0003 << sent);
            i_dir   = 1'b0;
            i_tag   = T'(sent);
            i_ready = !(c >= 3 && c < 8);
            cycle();
            if (!i_ready && !last_o_ready) ready_dropped = 1'b1;
            if (in_fire) sent++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        check("bp_ready_dropped", 128'(ready_dropped), 128'(1'b1));
        check("bp_words_out", 128'(n_out), 128'(8));
        check("bp_queue_empty", 128'(q.size()), 128'(0));

        // Random valid/ready toggling, scored against the model.
        n_out = 0; sent = 0; q.delete();
        for (int c = 0; c < 20000 && sent < 3000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = W'($urandom);
            i_dir   = 1'($urandom_range(0, 1));
            i_tag   = T'(sent);
            i_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (in_fire) sent++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() > 0; c++) cycle();
        check("rnd_words_in", 128'(sent), 128'(3000));
        check("rnd_words_out", 128'(n_out), 128'(3000));
        check("rnd_queue_empty", 128'(q.size()), 128'(0));

        // Reset with two words in flight
        tick();
        i_valid = 1'b1; i_data = 16'h0100; i_dir = 1'b0; i_tag = 4'd5;
        tick();
        i_data = 16'h0030; i_tag = 4'd6;
        tick();
        i_valid = 1'b0;
        check("pre_rst_valid", 128'(o_valid), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(o_valid), 128'(1'b0));
        check("mid_rst_outputs", 128'(observed()), 128'(0));
        check("mid_rst_ready", 128'(o_ready), 128'(1'b1));
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_idle", 128'(o_valid), 128'(1'b0));
        end
        i_valid = 1'b1; i_data = 16'h0003; i_dir = 1'b1; i_tag = 4'd9;
        tick();
        i_valid = 1'b0;
        check("post_rst_lat1", 128'(o_valid), 128'(1'b0));
        tick();
        check("post_rst_lat2", 128'(o_valid), 128'(1'b1));
        check("post_rst_word", 128'(observed()), 128'({1'b0, 4'd0, 16'h0003, 4'd9}));

        // 64-bit build
        w_valid = 1'b1; w_data = 64'h1; w_dir = 1'b0;
        tick();
        w_valid = 1'b0;
        tick();
        check("w64_valid", 128'(w_o_valid), 128'(1'b1));
        check("w64_pos_lead", 128'(w_pos), 128'(6'd63));
        check("w64_norm_lead", 128'(w_norm), 128'(64'h8000_0000_0000_0000));
        w_valid = 1'b1; w_data = 64'h8000_0000_0000_0000; w_dir = 1'b1;
        tick();
        w_valid = 1'b0;
        tick();
        check("w64_pos_trail", 128'(w_pos), 128'(6'd63));
        check("w64_norm_trail", 128'(w_norm), 128'(64'h1));
        check("w64_zero", 128'(w_zero), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
